// File: rtl/jfif_byte_feeder.sv
// One-entry holding stage between a JPEG byte source and jpeg_decoder that snoops the
// consumed stream for SOF0 dimensions, SOF1-3 and EOI. Optional byte counter: JFIF_BYTE_FEEDER_BYTE_CNT_EN.
module jfif_byte_feeder #(
  parameter int DIM_W = 16
) (
  input  logic             r_sysclk,
  input  logic             r_arst,
  input  logic             i_start,
  input  logic             i_src_valid,
  input  logic [7:0]       i_src_byte,
  output logic             o_src_ready,
  output logic             o_byte_en,
  output logic [7:0]       o_byte,
  input  logic             i_jfif_ready,
  output logic [DIM_W-1:0] o_width,
  output logic [DIM_W-1:0] o_height,
  output logic             o_dim_valid,
  output logic             o_unsupported,
  output logic             o_done,
  output logic [31:0]      o_byte_cnt
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t      state_q, state_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  hold_byte_q, hold_byte_d;
  logic        ff_seen_q, ff_seen_d;
  logic        sof_act_q, sof_act_d;
  logic [2:0]  sof_off_q, sof_off_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic        dim_vld_q, dim_vld_d;
  logic        unsup_q, unsup_d;
  logic        done_q, done_d;
  logic        src_rdy, load, consume, eoi;

  assign src_rdy = (state_q == STREAM) && (!hold_vld_q || i_jfif_ready);
  assign load    = i_src_valid && src_rdy;
  assign consume = (state_q == STREAM) && hold_vld_q && i_jfif_ready;

  always_comb begin
    state_d     = state_q;
    hold_vld_d  = hold_vld_q;
    hold_byte_d = hold_byte_q;
    ff_seen_d   = ff_seen_q;
    sof_act_d   = sof_act_q;
    sof_off_d   = sof_off_q;
    width_d     = width_q;
    height_d    = height_q;
    dim_vld_d   = dim_vld_q;
    unsup_d     = unsup_q;
    done_d      = done_q;
    eoi         = 1'b0;

    if (consume) begin
      hold_vld_d = 1'b0;
      ff_seen_d  = (hold_byte_q == 8'hFF);
      // Offset counts from the C0 byte itself; height precedes width in the SOF0 header.
      if (sof_act_q) begin
        case (sof_off_q)
          3'd4:    height_d[15:8] = hold_byte_q;
          3'd5:    height_d[7:0]  = hold_byte_q;
          3'd6:    width_d[15:8]  = hold_byte_q;
          3'd7:    width_d[7:0]   = hold_byte_q;
          default: ;
        endcase
        if (sof_off_q == 3'd7) begin
          sof_act_d = 1'b0;
          dim_vld_d = 1'b1;
        end else begin
          sof_off_d = sof_off_q + 3'd1;
        end
      end
      if (ff_seen_q) begin
        case (hold_byte_q)
          8'hC0: begin
            sof_act_d = 1'b1;
            sof_off_d = 3'd1;
          end
          8'hC1, 8'hC2, 8'hC3: unsup_d = 1'b1;
          8'hD9:   eoi = 1'b1;
          default: ;
        endcase
      end
    end

    if (load) begin
      hold_vld_d  = 1'b1;
      hold_byte_d = i_src_byte;
    end

    // A byte accepted in the same cycle as EOI belongs to nothing and is dropped.
    if (eoi) begin
      state_d    = DONE;
      done_d     = 1'b1;
      hold_vld_d = 1'b0;
    end

    if (i_start) begin
      state_d    = STREAM;
      hold_vld_d = 1'b0;
      ff_seen_d  = 1'b0;
      sof_act_d  = 1'b0;
      sof_off_d  = 3'd0;
      dim_vld_d  = 1'b0;
      unsup_d    = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) begin
      state_q     <= IDLE;
      hold_vld_q  <= 1'b0;
      hold_byte_q <= 8'h00;
      ff_seen_q   <= 1'b0;
      sof_act_q   <= 1'b0;
      sof_off_q   <= 3'd0;
      width_q     <= 16'h0000;
      height_q    <= 16'h0000;
      dim_vld_q   <= 1'b0;
      unsup_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_vld_q  <= hold_vld_d;
      hold_byte_q <= hold_byte_d;
      ff_seen_q   <= ff_seen_d;
      sof_act_q   <= sof_act_d;
      sof_off_q   <= sof_off_d;
      width_q     <= width_d;
      height_q    <= height_d;
      dim_vld_q   <= dim_vld_d;
      unsup_q     <= unsup_d;
      done_q      <= done_d;
    end
  end

`ifdef JFIF_BYTE_FEEDER_BYTE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (consume) cnt_d = cnt_q + 32'd1;
    if (i_start) cnt_d = 32'd0;
  end

  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) cnt_q <= 32'd0;
    else        cnt_q <= cnt_d;
  end

  assign o_byte_cnt = cnt_q;
`else
  assign o_byte_cnt = 32'd0;
`endif

  assign o_src_ready   = src_rdy;
  assign o_byte_en     = (state_q == STREAM) && hold_vld_q;
  assign o_byte        = hold_byte_q;
  assign o_width       = DIM_W'(width_q);
  assign o_height      = DIM_W'(height_q);
  assign o_dim_valid   = dim_vld_q;
  assign o_unsupported = unsup_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_jfif_byte_feeder.sv
// Bench for jfif_byte_feeder: a cycle-exact vector table for one full stream, then
// scoreboarded streams for stalls, stuffing, unsupported SOF, mid-stream reset and restart.
module tb_jfif_byte_feeder;
  localparam int DIM_W = 16;

  logic             r_sysclk = 1'b0;
  logic             r_arst = 1'b1;
  logic             i_start = 1'b0;
  logic             i_src_valid = 1'b0;
  logic [7:0]       i_src_byte = 8'h00;
  logic             i_jfif_ready = 1'b0;
  logic             o_src_ready, o_byte_en, o_dim_valid, o_unsupported, o_done;
  logic [7:0]       o_byte;
  logic [DIM_W-1:0] o_width, o_height;
  logic [31:0]      o_byte_cnt;

  int total = 0;
  int bad = 0;

  jfif_byte_feeder #(.DIM_W(DIM_W)) dut (
    .r_sysclk(r_sysclk), .r_arst(r_arst), .i_start(i_start),
    .i_src_valid(i_src_valid), .i_src_byte(i_src_byte), .o_src_ready(o_src_ready),
    .o_byte_en(o_byte_en), .o_byte(o_byte), .i_jfif_ready(i_jfif_ready),
    .o_width(o_width), .o_height(o_height), .o_dim_valid(o_dim_valid),
    .o_unsupported(o_unsupported), .o_done(o_done), .o_byte_cnt(o_byte_cnt)
  );

  always #5 r_sysclk = ~r_sysclk;

  typedef struct {
    logic       start;
    logic       vld;
    logic [7:0] b;
    logic       rdy;
    logic       e_rdy;
    logic       e_en;
    logic [7:0] e_b;
    logic       e_dimv;
    logic       e_done;
  } vec_t;

  vec_t vt[18];

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef JFIF_BYTE_FEEDER_BYTE_CNT_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start;
    i_start = 1'b1;
    @(posedge r_sysclk); #1;
    i_start = 1'b0;
  endtask

  // Feeds src with the source always valid; mode 1 makes the decoder ready 1 cycle in 3.
  task automatic run_stream(input logic [7:0] src[$], input int n_exp, input bit eoi,
                            input int mode, input string tag);
    int idx = 0;
    int k = 0;
    bit stall = 0;
    bit over = 0;
    bit early = 0;
    logic [7:0] stall_b = 8'h00;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      i_src_valid  = (idx < src.size());
      i_src_byte   = (idx < src.size()) ? src[idx] : 8'h00;
      i_jfif_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 2);
      @(negedge r_sysclk);
      if (stall) check({tag, " hold"}, 32'({o_byte_en, o_byte}), 32'({1'b1, stall_b}));
      if (o_done && k < n_exp) early = 1;
      if (o_byte_en && k >= n_exp) over = 1;
      else if (o_byte_en && i_jfif_ready) begin
        check({tag, " byte"}, 32'(o_byte), 32'(src[k]));
        k++;
      end
      stall   = o_byte_en && !i_jfif_ready;
      stall_b = o_byte;
      if (i_src_valid && o_src_ready) idx++;
      @(posedge r_sysclk); #1;
      if (k == n_exp && (!eoi || o_done)) break;
    end
    i_src_valid  = 1'b0;
    i_jfif_ready = 1'b0;
    check({tag, " consumed"}, 32'(k), 32'(n_exp));
    check({tag, " overrun"}, 32'(over), 32'd0);
    check({tag, " early_done"}, 32'(early), 32'd0);
    if (eoi) begin
      check({tag, " done"}, 32'(o_done), 32'd1);
      check({tag, " en_after_eoi"}, 32'(o_byte_en), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " src_ready"}, 32'(o_src_ready), 32'd0);
    check({tag, " byte_en"}, 32'(o_byte_en), 32'd0);
    check({tag, " byte"}, 32'(o_byte), 32'd0);
    check({tag, " width"}, 32'(o_width), 32'd0);
    check({tag, " height"}, 32'(o_height), 32'd0);
    check({tag, " dim_valid"}, 32'(o_dim_valid), 32'd0);
    check({tag, " unsupported"}, 32'(o_unsupported), 32'd0);
    check({tag, " done"}, 32'(o_done), 32'd0);
    check({tag, " byte_cnt"}, o_byte_cnt, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];

    // start, vld, byte, rdy | src_ready, byte_en, byte, dim_valid, done
    vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 8'hD8, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hD8, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 8'hC0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h08, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vt[14] = '{1'b0, 1'b1, 8'hD9, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[15] = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 8'hD9, 1'b1, 1'b0};
    vt[16] = '{1'b0, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    repeat (2) @(posedge r_sysclk);
    #1;
    check_all_zero("reset");
    #2 r_arst = 1'b0;
    @(posedge r_sysclk); #1;

    for (int i = 0; i < 18; i++) begin
      i_start      = vt[i].start;
      i_src_valid  = vt[i].vld;
      i_src_byte   = vt[i].b;
      i_jfif_ready = vt[i].rdy;
      @(negedge r_sysclk);
      check($sformatf("vec%0d src_ready", i), 32'(o_src_ready), 32'(vt[i].e_rdy));
      check($sformatf("vec%0d byte_en", i), 32'(o_byte_en), 32'(vt[i].e_en));
      if (vt[i].e_en) check($sformatf("vec%0d byte", i), 32'(o_byte), 32'(vt[i].e_b));
      check($sformatf("vec%0d dim_valid", i), 32'(o_dim_valid), 32'(vt[i].e_dimv));
      check($sformatf("vec%0d done", i), 32'(o_done), 32'(vt[i].e_done));
      @(posedge r_sysclk); #1;
    end
    i_start = 1'b0; i_src_valid = 1'b0; i_jfif_ready = 1'b0;
    check("tbl height", 32'(o_height), 32'd240);
    check("tbl width", 32'(o_width), 32'd320);
    check("tbl unsupported", 32'(o_unsupported), 32'd0);
    check("tbl byte_cnt", o_byte_cnt, exp_cnt(14));

    // Restart from DONE, second image under a 1-in-3 ready decoder.
    pulse_start();
    check("restart done", 32'(o_done), 32'd0);
    check("restart dim_valid", 32'(o_dim_valid), 32'd0);
    check("restart src_ready", 32'(o_src_ready), 32'd1);
    q = '{8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h11, 8'h08, 8'h01, 8'h02, 8'h01, 8'h03,
          8'h03, 8'h12, 8'h34, 8'hFF, 8'hD9, 8'hAA};
    run_stream(q, 16, 1, 1, "slow");
    check("slow height", 32'(o_height), 32'd258);
    check("slow width", 32'(o_width), 32'd259);
    check("slow dim_valid", 32'(o_dim_valid), 32'd1);
    check("slow byte_cnt", o_byte_cnt, exp_cnt(16));

    // Stuffed FF 00 and a padded FF FF D9 terminator.
    pulse_start();
    q = '{8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h22, 8'h08, 8'h00, 8'h10, 8'h00, 8'h20,
          8'h03, 8'h55, 8'hFF, 8'h00, 8'h66, 8'hFF, 8'hFF, 8'hD9, 8'h77};
    run_stream(q, 19, 1, 0, "stuff");
    check("stuff height", 32'(o_height), 32'd16);
    check("stuff width", 32'(o_width), 32'd32);
    check("stuff byte_cnt", o_byte_cnt, exp_cnt(19));

    // SOF2 flags unsupported without capturing; a later SOF0 still captures.
    pulse_start();
    q = '{8'hFF, 8'hD8, 8'hFF, 8'hC2, 8'h00, 8'h11, 8'h08, 8'h00, 8'h30, 8'h00, 8'h40, 8'h03};
    run_stream(q, 12, 0, 0, "sof2a");
    check("sof2 unsupported", 32'(o_unsupported), 32'd1);
    check("sof2 dim_valid", 32'(o_dim_valid), 32'd0);
    q = '{8'hFF, 8'hC0, 8'h00, 8'h11, 8'h08, 8'h00, 8'h50, 8'h00, 8'h60, 8'h03, 8'hFF, 8'hD9};
    run_stream(q, 12, 1, 1, "sof2b");
    check("sof2 height", 32'(o_height), 32'd80);
    check("sof2 width", 32'(o_width), 32'd96);
    check("sof2 dim_valid end", 32'(o_dim_valid), 32'd1);
    check("sof2 unsupported end", 32'(o_unsupported), 32'd1);
    check("sof2 byte_cnt", o_byte_cnt, exp_cnt(24));

    // Asynchronous reset right after SOF0 offset 5, then a clean stream.
    pulse_start();
    q = '{8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h11, 8'h08, 8'h00, 8'hF0};
    run_stream(q, 9, 0, 0, "pre_rst");
    #2 r_arst = 1'b1;
    #1 check_all_zero("midrst");
    #1 r_arst = 1'b0;
    @(posedge r_sysclk); #1;
    pulse_start();
    q = '{8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h11, 8'h08, 8'h01, 8'h23, 8'h00, 8'h45,
          8'h03, 8'hFF, 8'hD9};
    run_stream(q, 14, 1, 1, "post_rst");
    check("post_rst height", 32'(o_height), 32'd291);
    check("post_rst width", 32'(o_width), 32'd69);
    check("post_rst dim_valid", 32'(o_dim_valid), 32'd1);
    check("post_rst byte_cnt", o_byte_cnt, exp_cnt(14));

    // Start while a byte is held against a stalled decoder flushes it.
    pulse_start();
    i_src_valid = 1'b1; i_src_byte = 8'h5A; i_jfif_ready = 1'b0;
    @(negedge r_sysclk);
    check("flush load src_ready", 32'(o_src_ready), 32'd1);
    @(posedge r_sysclk); #1;
    i_src_valid = 1'b0; i_start = 1'b1;
    @(negedge r_sysclk);
    check("flush held", 32'({o_byte_en, o_byte}), 32'({1'b1, 8'h5A}));
    check("flush stall src_ready", 32'(o_src_ready), 32'd0);
    @(posedge r_sysclk); #1;
    i_start = 1'b0;
    check("flush byte_en", 32'(o_byte_en), 32'd0);
    check("flush src_ready", 32'(o_src_ready), 32'd1);
    check("flush byte_cnt", o_byte_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jfif_byte_feeder.md
JFIF_BYTE_FEEDER -- requirements
Module: jfif_byte_feeder

Interface
REQ-001 Parameter DIM_W, default 16: width of captured image width and height.
REQ-002 r_sysclk  in  1  system clock; all logic on rising edge.
REQ-003 r_arst  in  1  reset, asynchronous, active-high.
REQ-004 i_start  in  1  single-cycle pulse; arms feeder for a new JPEG stream.
REQ-005 i_src_valid  in  1  source byte valid.
REQ-006 i_src_byte  in  8  source JPEG byte.
REQ-007 o_src_ready  out  1  feeder accepts source byte this cycle.
REQ-008 o_byte_en  out  1  byte valid toward jpeg_decoder i_byte_en.
REQ-009 o_byte  out  8  byte toward jpeg_decoder i_byte.
REQ-010 i_jfif_ready  in  1  decoder o_jfif_ready; byte consumed when o_byte_en & i_jfif_ready.
REQ-011 o_width, o_height  out  DIM_W each  image size from SOF0.
REQ-012 o_dim_valid  out  1  level; width/height captured for current stream.
REQ-013 o_unsupported  out  1  level; SOF1/SOF2/SOF3 (FFC1..FFC3) seen.
REQ-014 o_done  out  1  level; EOI (FFD9) consumed by decoder.
REQ-015 o_byte_cnt  out  32  count of bytes consumed by decoder (see Configuration).

Function
REQ-016 States: IDLE, STREAM, DONE; reset enters IDLE.
REQ-017 IDLE: o_src_ready=0; i_start -> STREAM, clears o_dim_valid, o_unsupported, o_done, o_byte_cnt, marker tracker.
REQ-018 STREAM: one-entry holding register; o_byte_en = holding-valid; o_byte = held byte.
REQ-019 o_src_ready = STREAM & (~holding-valid | i_jfif_ready), combinational; full throughput one byte/cycle when decoder ready.
REQ-020 Source byte loaded when i_src_valid & o_src_ready; holding register cleared on consume with no new load.
REQ-021 o_byte stable while o_byte_en=1 and i_jfif_ready=0.
REQ-022 Marker parsing operates only on consumed bytes (o_byte_en & i_jfif_ready), in consumption order.
REQ-023 FF-seen flag: set on consumed 0xFF; following 0xFF keeps it set; any other byte clears it after evaluation.
REQ-024 FF followed by 0x00 (stuffing) is data, no marker action.
REQ-025 FF C0: SOF0 field counter starts; counting C0 as offset 0, offsets 4,5 -> o_height[15:8],[7:0]; offsets 6,7 -> o_width[15:8],[7:0].
REQ-026 o_dim_valid set on the cycle after offset 7 consumed; stays set until next i_start.
REQ-027 DIM_W<16: low DIM_W bits stored; DIM_W>16: upper bits zero.
REQ-028 FF C1/C2/C3: o_unsupported set, streaming continues.
REQ-029 FF D9 consumed: next cycle state DONE, o_done=1, holding register emptied; any byte already loaded after D9 is dropped.
REQ-030 DONE: o_src_ready=0, o_byte_en=0; i_start -> STREAM as REQ-017.
REQ-031 i_start in STREAM: restarts (REQ-017), holding register flushed same cycle.
REQ-032 No o_byte_en assertion outside STREAM.

Reset
REQ-033 On r_arst: state IDLE, o_src_ready=0, o_byte_en=0, o_byte=0, o_width=0, o_height=0, o_dim_valid=0, o_unsupported=0, o_done=0, o_byte_cnt=0.
REQ-034 Reset mid-stream discards held byte and partial SOF capture immediately (asynchronous).

Configuration
REQ-035 Macro JFIF_BYTE_FEEDER_BYTE_CNT_EN defined: o_byte_cnt increments per consumed byte, wraps at 2^32, includes EOI bytes, frozen in DONE.
REQ-036 Macro undefined: counter logic omitted, o_byte_cnt tied 0; all other behaviour identical.

Verification
REQ-037 Stream FF D8 FF C0 00 11 08 00 F0 01 40 03 .. FF D9, i_jfif_ready=1 -> o_height=240, o_width=320, o_dim_valid=1, o_done=1, byte count equals stream length (macro on).
REQ-038 i_jfif_ready toggling 1-of-3 cycles, source always valid -> o_byte holds while not ready, byte sequence at decoder identical to source, no loss/duplication.
REQ-039 Scan data containing FF 00 and FF FF D9 -> FF 00 no action; FF FF D9 terminates, o_done=1, byte after D9 never presented.
REQ-040 Stream with FF C2 -> o_unsupported=1, o_dim_valid=0 until any later SOF0 completes, o_done on EOI.
REQ-041 r_arst asserted after SOF0 offset 5 -> all outputs zero, IDLE; i_start then full stream -> correct dims.
REQ-042 i_start in DONE -> o_done, o_dim_valid cleared next cycle, o_src_ready=1, second image dimensions captured.
